// File: rtl/bip_debug_unit.sv
// bip_debug_unit: post-HALT observer for the BIP core.
// Counts execution cycles until HALT, snapshots PC/ACC/count, reads back
// data memory words 0..DUMP_WORDS-1 over a spare read port and serialises
// the result as a byte stream with a valid/ready handshake for a UART TX.
// Frame: HEADER, PC(2), ACC(2), COUNT(4), mem words (2 bytes each), MSB first.
// Optional feature: define DBG_CHECKSUM_EN to append one XOR byte covering
// every frame byte except HEADER.
module bip_debug_unit #(
    parameter int          DUMP_WORDS = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_i,
    input  logic [10:0] pc_i,
    input  logic [15:0] acc_i,
    output logic        mem_rd_o,
    output logic [10:0] mem_addr_o,
    input  logic [15:0] mem_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [10:0] LAST_WORD  = 11'(DUMP_WORDS - 1);
    localparam logic [3:0]  LAST_FIXED = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_MEM_H,
        S_MEM_L,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [15:0] pc_q;
    logic [15:0] acc_q;
    logic [3:0]  byte_idx_q;
    logic [3:0]  next_idx;
    logic [7:0]  next_fixed_byte;
    logic [7:0]  mem_lo_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        mem_rd_q;
    logic [10:0] mem_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        xfer;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign xfer     = tx_valid_q & tx_ready_i;
    assign next_idx = byte_idx_q + 4'd1;
    assign count_d  = (&count_q) ? count_q : count_q + 32'd1;

    // Select the fixed-field byte that follows the one currently on the bus.
    // NOTE: the default assignment first keeps this purely combinational; a
    // missing default on any path would infer a latch.
    always_comb begin
        next_fixed_byte = HEADER;
        case (next_idx)
            4'd1:    next_fixed_byte = pc_q[15:8];
            4'd2:    next_fixed_byte = pc_q[7:0];
            4'd3:    next_fixed_byte = acc_q[15:8];
            4'd4:    next_fixed_byte = acc_q[7:0];
            4'd5:    next_fixed_byte = count_q[31:24];
            4'd6:    next_fixed_byte = count_q[23:16];
            4'd7:    next_fixed_byte = count_q[15:8];
            4'd8:    next_fixed_byte = count_q[7:0];
            default: next_fixed_byte = HEADER;
        endcase
    end

    // Frame FSM: cycle counting, snapshot, memory readback and byte handshake.
    // All outputs are registered so tx_valid never depends on tx_ready.
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            pc_q       <= '0;
            acc_q      <= '0;
            byte_idx_q <= '0;
            mem_lo_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DBG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (halt_i) begin
                        pc_q       <= {5'b0, pc_i};
                        acc_q      <= acc_i;
                        byte_idx_q <= '0;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        count_q <= count_d;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
`ifdef DBG_CHECKSUM_EN
                        if (byte_idx_q != 4'd0) csum_q <= csum_q ^ tx_data_q;
`endif
                        if (byte_idx_q == LAST_FIXED) begin
                            tx_valid_q <= 1'b0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= '0;
                            state_q    <= S_MEM_REQ;
                        end else begin
                            tx_data_q  <= next_fixed_byte;
                            byte_idx_q <= next_idx;
                        end
                    end
                end
                S_MEM_REQ: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    mem_lo_q   <= mem_data_i[7:0];
                    tx_data_q  <= mem_data_i[15:8];
                    tx_valid_q <= 1'b1;
                    state_q    <= S_MEM_H;
                end
                S_MEM_H: begin
                    if (xfer) begin
`ifdef DBG_CHECKSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        tx_data_q <= mem_lo_q;
                        state_q   <= S_MEM_L;
                    end
                end
                S_MEM_L: begin
                    if (xfer) begin
`ifdef DBG_CHECKSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        if (mem_addr_q == LAST_WORD) begin
`ifdef DBG_CHECKSUM_EN
                            tx_data_q <= csum_q ^ tx_data_q;
                            state_q   <= S_CSUM;
`else
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
`endif
                        end else begin
                            tx_valid_q <= 1'b0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= mem_addr_q + 11'd1;
                            state_q    <= S_MEM_REQ;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Testbench for bip_debug_unit: scoreboard of expected frame bytes, a
// behavioural data memory, and directed scenarios covering idle, counting,
// back-pressure, mid-frame reset, halt at reset release and halt drop.
module tb_bip_debug_unit;

    localparam int DUMP = 16;
`ifdef DBG_CHECKSUM_EN
    localparam int FRAME_LEN = 10 + 2 * DUMP;
`else
    localparam int FRAME_LEN = 9 + 2 * DUMP;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [10:0] pc;
    logic [15:0] acc;
    logic        mem_rd;
    logic [10:0] mem_addr;
    logic [15:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int rx_count = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];

    logic       prev_valid  = 1'b0;
    logic       prev_ready  = 1'b0;
    logic [7:0] prev_data   = 8'h00;
    logic       prev_mem_rd = 1'b0;
    logic       prev_rst    = 1'b1;

    bip_debug_unit #(.DUMP_WORDS(DUMP), .HEADER(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_i     (halt),
        .pc_i       (pc),
        .acc_i      (acc),
        .mem_rd_o   (mem_rd),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    // Data memory model: mem[i] = i*16'h0101, data valid the cycle after mem_rd.
    always @(posedge clk) begin
        mem_data <= mem_rd ? {mem_addr[7:0], mem_addr[7:0]} : 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected frame for a given snapshot, pushed to the scoreboard.
    task automatic push_frame(input logic [15:0] p, input logic [15:0] a, input logic [31:0] c);
        logic [7:0] b[$];
        logic [7:0] x;
        logic [15:0] w;
        b.push_back(8'hA5);
        b.push_back(p[15:8]);  b.push_back(p[7:0]);
        b.push_back(a[15:8]);  b.push_back(a[7:0]);
        b.push_back(c[31:24]); b.push_back(c[23:16]);
        b.push_back(c[15:8]);  b.push_back(c[7:0]);
        for (int i = 0; i < DUMP; i++) begin
            w = 16'(i) * 16'h0101;
            b.push_back(w[15:8]);
            b.push_back(w[7:0]);
        end
        x = 8'h00;
        for (int i = 1; i < b.size(); i++) x = x ^ b[i];
`ifdef DBG_CHECKSUM_EN
        b.push_back(x);
`endif
        exp_q.delete();
        foreach (b[i]) exp_q.push_back(b[i]);
        rx_count  = 0;
        pulse_cnt = 0;
    endtask

    // Sample outputs on the falling edge; these describe the next rising edge.
    task automatic monitor();
        logic [7:0] e;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_byte observed=%h expected=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", rx_count), 32'(tx_data), 32'(e));
                end
                rx_count++;
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (mem_rd) begin
                check("mem_rd_width", 32'(prev_mem_rd), 32'd0);
                check("mem_rd_busy", 32'(busy), 32'd1);
                check("mem_addr", 32'(mem_addr), 32'(pulse_cnt));
                pulse_cnt++;
            end
        end
        prev_valid  = tx_valid;
        prev_ready  = tx_ready;
        prev_data   = tx_data;
        prev_mem_rd = mem_rd;
        prev_rst    = rst;
    endtask

    // One clock: sample at negedge, return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Run until the frame completes, then check its closing conditions.
    task automatic run_frame(input bit rand_ready, input bit drop_halt);
        int n = 0;
        int rx_end;
        while (!(done === 1'b1 && exp_q.size() == 0) && n < 3000) begin
            step();
            tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (drop_halt && rx_count >= 2) begin
                halt = 1'b0;
                pc   = 11'h7FF;
                acc  = 16'hFFFF;
            end
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $error("FAIL frame_timeout observed=%0d bytes expected=%0d", rx_count, FRAME_LEN);
        end
        check("frame_len", 32'(rx_count), 32'(FRAME_LEN));
        check("mem_rd_pulses", 32'(pulse_cnt), 32'(DUMP));
        check("done_set", 32'(done), 32'd1);
        check("busy_clear", 32'(busy), 32'd0);
        check("tx_valid_clear", 32'(tx_valid), 32'd0);
        rx_end = rx_count;
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            halt = i[0];
            step();
            check("done_sticky", {29'd0, done, tx_valid, mem_rd}, 32'h4);
        end
        check("no_more_bytes", 32'(rx_count), 32'(rx_end));
    endtask

    initial begin
        rst      = 1'b1;
        halt     = 1'b0;
        pc       = 11'h005;
        acc      = 16'h1234;
        tx_ready = 1'b1;

        // Reset state, then 20 idle cycles with no activity.
        do_reset();
        check("reset_outputs", {mem_rd, mem_addr, tx_data, tx_valid, busy, done}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_quiet", {28'd0, tx_valid, mem_rd, busy, done}, 32'd0);
        end

        // Nominal frame, tx_ready constant: COUNT=10.
        do_reset();
        push_frame(16'h0005, 16'h1234, 32'd10);
        repeat (10) step();
        halt = 1'b1;
        run_frame(1'b0, 1'b0);

        // Same frame with 30% ready duty.
        halt = 1'b0;
        do_reset();
        push_frame(16'h0005, 16'h1234, 32'd10);
        repeat (10) step();
        halt = 1'b1;
        run_frame(1'b1, 1'b0);

        // Reset after the 5th byte, then a fresh frame with COUNT=3.
        halt = 1'b0;
        do_reset();
        push_frame(16'h0005, 16'h1234, 32'd10);
        repeat (10) step();
        halt = 1'b1;
        for (int n = 0; n < 200 && rx_count < 5; n++) step();
        check("five_bytes", 32'(rx_count), 32'd5);
        rst      = 1'b1;
        halt     = 1'b0;
        tx_ready = 1'b0;
        step();
        check("abort_outputs", {mem_rd, mem_addr, tx_data, tx_valid, busy, done}, 32'd0);
        rst = 1'b0;
        push_frame(16'h0005, 16'h1234, 32'd3);
        tx_ready = 1'b1;
        repeat (3) step();
        halt = 1'b1;
        run_frame(1'b0, 1'b0);

        // halt already high at reset release: COUNT=0.
        halt = 1'b1;
        pc   = 11'h3A7;
        acc  = 16'hBEEF;
        push_frame(16'h03A7, 16'hBEEF, 32'd0);
        do_reset();
        run_frame(1'b0, 1'b0);

        // halt drops after byte 2 with new pc/acc: snapshot unchanged.
        halt = 1'b0;
        pc   = 11'h005;
        acc  = 16'h1234;
        do_reset();
        push_frame(16'h0005, 16'h1234, 32'd10);
        repeat (10) step();
        halt = 1'b1;
        run_frame(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
